// File: rtl/calc_port_responder.sv
// calc_port_responder
//   Two-cycle command intake (command + operand1, then operand2) feeding a
//   one-cycle execute stage. Add/sub/invalid results go straight into a
//   4-deep response FIFO. Shift results take two extra pipeline stages before
//   reaching the FIFO. The FIFO accepts two writes per cycle, with the older
//   (shift) result first, and pops one response per cycle onto the outputs.
//   A per-tag outstanding mask drops commands whose tag is still in flight.
//
//   Optional feature: define CALC_SHIFT_EN to execute cmds 5/6 as logical
//   shifts; otherwise they are answered as invalid and the shift pipeline
//   is not built.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   cmd_in    [3:0]  0 none, 1 add, 2 sub, 5 shl, 6 shr, others invalid
//   data_in   [31:0] operand1 in the command cycle, operand2 the cycle after
//   tag_in    [1:0]  command tag, sampled with the command
//   data_out  [31:0] response data (0 when no response)
//   tag_out   [1:0]  response tag (0 when no response)
//   resp_out  [1:0]  0 idle, 1 success, 2 error
module calc_port_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  cmd_in,
    input  logic [31:0] data_in,
    input  logic [1:0]  tag_in,
    output logic [31:0] data_out,
    output logic [1:0]  tag_out,
    output logic [1:0]  resp_out
);
    localparam logic [3:0] CMD_NONE = 4'd0;
    localparam logic [3:0] CMD_ADD  = 4'd1;
    localparam logic [3:0] CMD_SUB  = 4'd2;
`ifdef CALC_SHIFT_EN
    localparam logic [3:0] CMD_SHL  = 4'd5;
    localparam logic [3:0] CMD_SHR  = 4'd6;
`endif
    localparam logic [1:0] RESP_IDLE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;
    localparam int         FIFO_DEPTH = 4;

    typedef enum logic { ST_IDLE, ST_OP2 } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  tag;
        logic [1:0]  resp;
    } rsp_t;

    // intake
    state_t      state_q, state_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [1:0]  tag_q, tag_d;
    logic [31:0] op1_q, op1_d;
    logic        accept;

    // execute stage
    logic        ex_vld_q, ex_vld_d;
    logic [3:0]  ex_cmd_q, ex_cmd_d;
    logic [1:0]  ex_tag_q, ex_tag_d;
    logic [31:0] ex_op1_q, ex_op1_d;
    logic [31:0] ex_op2_q, ex_op2_d;
    logic [32:0] ex_sum;
    logic        ex_is_shift;
    rsp_t        ex_rsp;

`ifdef CALC_SHIFT_EN
    // shift pipeline
    logic        sh1_vld_q, sh1_vld_d;
    logic        sh2_vld_q, sh2_vld_d;
    rsp_t        sh1_q, sh1_d;
    rsp_t        sh2_q, sh2_d;
`endif

    // response FIFO
    rsp_t        mem_q [0:FIFO_DEPTH-1];
    rsp_t        mem_d [0:FIFO_DEPTH-1];
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  free;
    logic        pop;
    rsp_t        head;
    logic        wa_vld, wb_vld;
    rsp_t        wa, wb;
    logic        first_vld, second_vld, first_ok, second_ok;
    rsp_t        first, second;

    // outstanding tags
    logic [3:0]  mask_q, mask_d;

    // ------------------------------------------------------------------
    // Intake: IDLE takes command + operand1, OP2 takes operand2 and hands
    // the whole command to the execute stage. cmd_in is ignored in OP2.
    // ------------------------------------------------------------------
    always_comb begin
        accept   = (state_q == ST_IDLE) && (cmd_in != CMD_NONE) && !mask_q[tag_in];
        state_d  = state_q;
        cmd_d    = cmd_q;
        tag_d    = tag_q;
        op1_d    = op1_q;
        ex_vld_d = 1'b0;
        ex_cmd_d = ex_cmd_q;
        ex_tag_d = ex_tag_q;
        ex_op1_d = ex_op1_q;
        ex_op2_d = ex_op2_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_OP2;
                    cmd_d   = cmd_in;
                    tag_d   = tag_in;
                    op1_d   = data_in;
                end
            end
            ST_OP2: begin
                state_d  = ST_IDLE;
                ex_vld_d = 1'b1;
                ex_cmd_d = cmd_q;
                ex_tag_d = tag_q;
                ex_op1_d = op1_q;
                ex_op2_d = data_in;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Execute: errors always return data 0.
    // ------------------------------------------------------------------
    always_comb begin
        ex_sum      = {1'b0, ex_op1_q} + {1'b0, ex_op2_q};
        ex_is_shift = 1'b0;
        ex_rsp.data = 32'd0;
        ex_rsp.tag  = ex_tag_q;
        ex_rsp.resp = RESP_ERR;
        case (ex_cmd_q)
            CMD_ADD: begin
                if (!ex_sum[32]) begin
                    ex_rsp.data = ex_sum[31:0];
                    ex_rsp.resp = RESP_OK;
                end
            end
            CMD_SUB: begin
                if (ex_op2_q <= ex_op1_q) begin
                    ex_rsp.data = ex_op1_q - ex_op2_q;
                    ex_rsp.resp = RESP_OK;
                end
            end
`ifdef CALC_SHIFT_EN
            CMD_SHL: begin
                ex_is_shift = 1'b1;
                ex_rsp.data = ex_op1_q << ex_op2_q[4:0];
                ex_rsp.resp = RESP_OK;
            end
            CMD_SHR: begin
                ex_is_shift = 1'b1;
                ex_rsp.data = ex_op1_q >> ex_op2_q[4:0];
                ex_rsp.resp = RESP_OK;
            end
`endif
            default: ;
        endcase
    end

`ifdef CALC_SHIFT_EN
    // Shift result is computed in the execute stage and then delayed two
    // cycles so it lands in the FIFO at N+4.
    always_comb begin
        sh1_vld_d = ex_vld_q && ex_is_shift;
        sh1_d     = ex_rsp;
        sh2_vld_d = sh1_vld_q;
        sh2_d     = sh1_q;
    end
`endif

    // ------------------------------------------------------------------
    // Response FIFO: port A (shift pipe) is always older than port B
    // (execute stage), so A is packed into the first free slot.
    // ------------------------------------------------------------------
    assign head = mem_q[rd_ptr_q];
    assign pop  = (cnt_q != 3'd0);

    always_comb begin
`ifdef CALC_SHIFT_EN
        wa_vld = sh2_vld_q;
        wa     = sh2_q;
`else
        wa_vld = 1'b0;
        wa     = '0;
`endif
        wb_vld     = ex_vld_q && !ex_is_shift;
        wb         = ex_rsp;
        first_vld  = wa_vld || wb_vld;
        first      = wa_vld ? wa : wb;
        second_vld = wa_vld && wb_vld;
        second     = wb;

        // Unique tags bound occupancy to 4, so these guards never drop a
        // write in practice; they only keep the pointers consistent.
        free      = 3'(FIFO_DEPTH) - cnt_q + {2'b00, pop};
        first_ok  = first_vld && (free != 3'd0);
        second_ok = second_vld && (free >= 3'd2);

        for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
        if (first_ok)  mem_d[wr_ptr_q]         = first;
        if (second_ok) mem_d[wr_ptr_q + 2'd1]  = second;

        wr_ptr_d = wr_ptr_q + {1'b0, first_ok} + {1'b0, second_ok};
        rd_ptr_d = rd_ptr_q + {1'b0, pop};
        cnt_d    = cnt_q + {2'b00, first_ok} + {2'b00, second_ok} - {2'b00, pop};
    end

    // A popped tag cannot be the one being accepted: acceptance needs its
    // mask bit clear while a queued response has its bit set.
    always_comb begin
        mask_d = mask_q;
        if (pop)    mask_d[head.tag] = 1'b0;
        if (accept) mask_d[tag_in]   = 1'b1;
    end

    // Head of the FIFO is presented for exactly the cycle it is popped.
    assign data_out = pop ? head.data : 32'd0;
    assign tag_out  = pop ? head.tag  : 2'd0;
    assign resp_out = pop ? head.resp : RESP_IDLE;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            tag_q     <= '0;
            op1_q     <= '0;
            ex_vld_q  <= 1'b0;
            ex_cmd_q  <= '0;
            ex_tag_q  <= '0;
            ex_op1_q  <= '0;
            ex_op2_q  <= '0;
`ifdef CALC_SHIFT_EN
            sh1_vld_q <= 1'b0;
            sh2_vld_q <= 1'b0;
            sh1_q     <= '0;
            sh2_q     <= '0;
`endif
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            tag_q     <= tag_d;
            op1_q     <= op1_d;
            ex_vld_q  <= ex_vld_d;
            ex_cmd_q  <= ex_cmd_d;
            ex_tag_q  <= ex_tag_d;
            ex_op1_q  <= ex_op1_d;
            ex_op2_q  <= ex_op2_d;
`ifdef CALC_SHIFT_EN
            sh1_vld_q <= sh1_vld_d;
            sh2_vld_q <= sh2_vld_d;
            sh1_q     <= sh1_d;
            sh2_q     <= sh2_d;
`endif
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
        end
    end

    // FIFO storage needs no reset: occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end

endmodule

// File: tb/tb_calc_port_responder.sv
// Testbench for calc_port_responder: directed scenarios followed by a long
// random stream, all checked against a queue-based reference model.
module tb_calc_port_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cmd_in;
    logic [31:0] data_in;
    logic [1:0]  tag_in;
    logic [31:0] data_out;
    logic [1:0]  tag_out;
    logic [1:0]  resp_out;

    always #5 clk = ~clk;

    calc_port_responder dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_in   (cmd_in),
        .data_in  (data_in),
        .tag_in   (tag_in),
        .data_out (data_out),
        .tag_out  (tag_out),
        .resp_out (resp_out)
    );

    typedef struct {
        int          cyc;   // write cycle (pending) or output cycle (observed)
        logic [31:0] data;
        logic [1:0]  tag;
        logic [1:0]  resp;
    } ent_t;

    ent_t pend_q[$];   // computed results not yet in the response queue
    ent_t exp_q[$];    // expected responses, in delivery order
    ent_t obs_q[$];    // responses seen on the outputs

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference intake state
    bit          m_op2  = 1'b0;
    logic [3:0]  m_cmd;
    logic [1:0]  m_tag;
    logic [31:0] m_op1;
    logic [3:0]  m_mask = 4'd0;
    bit          prev_rst = 1'b0;

    // Result of a command and the number of cycles from its operand2 cycle
    // until it is written into the response queue.
    function automatic void ref_exec(input logic [3:0] c, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] d,
                                     output logic [1:0] r, output int lat);
        logic [63:0] s;
        d   = 32'd0;
        r   = 2'd2;
        lat = 1;
        s   = {32'd0, a} + {32'd0, b};
        case (c)
            4'd1: if (s <= 64'hFFFF_FFFF) begin d = s[31:0]; r = 2'd1; end
            4'd2: if (b <= a) begin d = a - b; r = 2'd1; end
`ifdef CALC_SHIFT_EN
            4'd5: begin d = a << b[4:0]; r = 2'd1; lat = 3; end
            4'd6: begin d = a >> b[4:0]; r = 2'd1; lat = 3; end
`endif
            default: ;
        endcase
    endfunction

    initial forever @(posedge clk) cyc++;

    // Reference model + scoreboard, evaluated mid-cycle.
    initial forever begin
        @(negedge clk);
        if (prev_rst) begin
            n_cmp++;
            if (data_out !== 32'd0 || tag_out !== 2'd0 || resp_out !== 2'd0) begin
                n_bad++;
                $display("FAIL rst_out cyc=%0d got data=%h tag=%0d resp=%0d, required all 0",
                         cyc, data_out, tag_out, resp_out);
            end
        end
        prev_rst = reset;
        if (reset) begin
            pend_q.delete();
            exp_q.delete();
            m_op2  = 1'b0;
            m_mask = 4'd0;
        end else begin
            ent_t e;
            // intake
            if (m_op2) begin
                int lat;
                ref_exec(m_cmd, m_op1, data_in, e.data, e.resp, lat);
                e.tag = m_tag;
                e.cyc = cyc + lat;
                pend_q.push_back(e);
                m_op2 = 1'b0;
            end else if (cmd_in != 4'd0 && !m_mask[tag_in]) begin
                m_cmd  = cmd_in;
                m_tag  = tag_in;
                m_op1  = data_in;
                m_mask[tag_in] = 1'b1;
                m_op2  = 1'b1;
            end
            // output check
            n_cmp++;
            if (resp_out != 2'd0) begin
                obs_q.push_back('{cyc, data_out, tag_out, resp_out});
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_rsp cyc=%0d got data=%h tag=%0d resp=%0d, required none",
                             cyc, data_out, tag_out, resp_out);
                end else begin
                    e = exp_q.pop_front();
                    m_mask[e.tag] = 1'b0;
                    if (data_out !== e.data || tag_out !== e.tag || resp_out !== e.resp) begin
                        n_bad++;
                        $display("FAIL rsp cyc=%0d got data=%h tag=%0d resp=%0d, required data=%h tag=%0d resp=%0d",
                                 cyc, data_out, tag_out, resp_out, e.data, e.tag, e.resp);
                    end
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                m_mask[e.tag] = 1'b0;
                n_bad++;
                $display("FAIL missing_rsp cyc=%0d got resp=0, required data=%h tag=%0d resp=%0d",
                         cyc, e.data, e.tag, e.resp);
            end else if (data_out !== 32'd0 || tag_out !== 2'd0) begin
                n_bad++;
                $display("FAIL idle_nonzero cyc=%0d got data=%h tag=%0d, required 0",
                         cyc, data_out, tag_out);
            end
            // results finishing this cycle join the queue in issue order
            for (int i = 0; i < pend_q.size(); ) begin
                if (pend_q[i].cyc == cyc) begin
                    exp_q.push_back(pend_q[i]);
                    pend_q.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    task automatic step(input logic r, input logic [3:0] c, input logic [1:0] t,
                        input logic [31:0] d);
        @(posedge clk);
        #1;
        reset   = r;
        cmd_in  = c;
        tag_in  = t;
        data_in = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 2'd0, 32'd0);
    endtask

    task automatic chk_obs(input string nm, input int c, input logic [1:0] t,
                           input logic [31:0] d, input logic [1:0] r);
        int idx = -1;
        for (int i = 0; i < obs_q.size(); i++) if (obs_q[i].cyc == c) idx = i;
        n_cmp++;
        if (idx < 0) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got no response, required data=%h tag=%0d resp=%0d",
                     nm, c, d, t, r);
        end else if (obs_q[idx].data !== d || obs_q[idx].tag !== t || obs_q[idx].resp !== r) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got data=%h tag=%0d resp=%0d, required data=%h tag=%0d resp=%0d",
                     nm, c, obs_q[idx].data, obs_q[idx].tag, obs_q[idx].resp, d, t, r);
        end
    endtask

    task automatic chk_cnt(input string nm, input int lo, input int hi, input int want);
        int n = 0;
        for (int i = 0; i < obs_q.size(); i++)
            if (obs_q[i].cyc >= lo && obs_q[i].cyc <= hi) n++;
        n_cmp++;
        if (n != want) begin
            n_bad++;
            $display("FAIL %s cycles %0d..%0d got %0d responses, required %0d", nm, lo, hi, n, want);
        end
    endtask

    initial begin
        int n, n2;
        reset   = 1'b1;
        cmd_in  = 4'd0;
        tag_in  = 2'd0;
        data_in = 32'd0;
        repeat (3) step(1'b1, 4'd0, 2'd0, 32'd0);
        idle(2);

        // add 5+7, tag 1; cmd_in in the operand2 cycle must be ignored
        step(1'b0, 4'd1, 2'd1, 32'd5); n = cyc;
        step(1'b0, 4'd2, 2'd3, 32'd7);
        idle(6);
        chk_obs("add_ok", n + 3, 2'd1, 32'd12, 2'd1);
        chk_cnt("add_once", n, n + 7, 1);

        // add carry and sub underflow
        step(1'b0, 4'd1, 2'd2, 32'hFFFF_FFFF); n = cyc;
        step(1'b0, 4'd0, 2'd0, 32'd1);
        step(1'b0, 4'd2, 2'd3, 32'd3); n2 = cyc;
        step(1'b0, 4'd0, 2'd0, 32'd4);
        idle(6);
        chk_obs("add_carry", n + 3, 2'd2, 32'd0, 2'd2);
        chk_obs("sub_under", n2 + 3, 2'd3, 32'd0, 2'd2);

`ifdef CALC_SHIFT_EN
        // shift completes together with a later add; shift goes first
        step(1'b0, 4'd5, 2'd0, 32'd1); n = cyc;
        step(1'b0, 4'd0, 2'd0, 32'h24);
        step(1'b0, 4'd1, 2'd3, 32'd1);
        step(1'b0, 4'd0, 2'd0, 32'd1);
        idle(8);
        chk_obs("shl_first", n + 5, 2'd0, 32'd16, 2'd1);
        chk_obs("add_after_shl", n + 6, 2'd3, 32'd2, 2'd1);
`else
        step(1'b0, 4'd6, 2'd2, 32'd8); n = cyc;
        step(1'b0, 4'd0, 2'd0, 32'd1);
        idle(6);
        chk_obs("shr_disabled", n + 3, 2'd2, 32'd0, 2'd2);
`endif

        // invalid cmd, then a duplicate tag while still outstanding
        step(1'b0, 4'd9, 2'd1, 32'd11); n = cyc;
        step(1'b0, 4'd0, 2'd0, 32'd22);
        step(1'b0, 4'd9, 2'd1, 32'd33);
        step(1'b0, 4'd0, 2'd0, 32'd44);
        idle(6);
        chk_obs("invalid", n + 3, 2'd1, 32'd0, 2'd2);
        chk_cnt("dup_drop", n, n + 9, 1);

        // reset during OP2 discards the add; tag 1 reusable right after
        step(1'b0, 4'd1, 2'd1, 32'd10); n = cyc;
        step(1'b1, 4'd0, 2'd0, 32'd20);
        step(1'b0, 4'd1, 2'd1, 32'd3); n2 = cyc;
        step(1'b0, 4'd0, 2'd0, 32'd4);
        idle(8);
        chk_cnt("rst_discard", n, n2 + 2, 0);
        chk_obs("post_rst_add", n2 + 3, 2'd1, 32'd7, 2'd1);

        // random stream
        for (int i = 0; i < 5000; i++) begin
            logic [3:0]  c;
            logic [31:0] d;
            int k = $urandom_range(0, 11);
            case (k)
                0, 1, 2, 3: c = 4'd0;
                4, 5:       c = 4'd1;
                6, 7:       c = 4'd2;
                8:          c = 4'd5;
                9:          c = 4'd6;
                10:         c = 4'(($urandom_range(0, 1) == 0) ? 3 : 9);
                default:    c = 4'($urandom_range(7, 15));
            endcase
            k = $urandom_range(0, 3);
            if (k == 0)      d = 32'($urandom_range(0, 40));
            else if (k == 1) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            else             d = $urandom;
            step(($urandom_range(0, 299) == 0), c, 2'($urandom_range(0, 3)), d);
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/calc_port_responder.md
CALC_PORT_RESPONDER -- requirements
Module: calc_port_responder

Interface
REQ-001 The block SHALL use a single clock `clk`; reset `reset` SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 cmd_in  input  4  command: 0 none, 1 add, 2 sub, 5 shift-left, 6 shift-right.
REQ-005 data_in  input  32  operand1 in the command cycle; operand2 in the following cycle.
REQ-006 tag_in  input  2  command tag, sampled in the command cycle.
REQ-007 data_out  output  32  result; 0 when resp_out is 0.
REQ-008 tag_out  output  2  tag of the returned response; 0 when resp_out is 0.
REQ-009 resp_out  output  2  0 idle, 1 success, 2 error (overflow, underflow or invalid); 3 is never driven.

Function
REQ-010 Cycle N with cmd_in≠0 (intake state IDLE) SHALL capture cmd, tag and operand1 and move to state OP2.
REQ-011 In OP2 (cycle N+1) the block SHALL capture operand2, ignore cmd_in, and return to IDLE; the next command is accepted at N+2.
REQ-012 Add SHALL be unsigned 32-bit; a carry out SHALL give resp 2 with data 0.
REQ-013 Sub SHALL compute op1−op2; op2>op1 SHALL give resp 2 with data 0.
REQ-014 Shifts SHALL be logical, with the shift amount taken from the low 5 bits of operand2; resp is always 1.
REQ-015 Any other nonzero cmd SHALL consume the operand2 cycle and give resp 2 with data 0.
REQ-016 Add, sub and invalid results SHALL be written into the response FIFO at the end of N+2 and appear on the outputs at N+3 if the FIFO is empty.
REQ-017 Shift results SHALL pass through a 2-stage pipeline and appear at N+5 if the FIFO is empty; completion order may therefore differ from issue order.
REQ-018 The response FIFO SHALL be 4 deep and accept 2 writes per cycle; when two results complete in the same cycle, the older command (the shift) SHALL be written first.
REQ-019 The FIFO SHALL pop at most one entry per cycle; each response SHALL be driven for exactly one cycle, with data_out, tag_out and resp_out all zero otherwise.
REQ-020 A 4-bit outstanding-tag mask SHALL be set at acceptance and cleared when the response is driven.
REQ-021 A command whose tag is already outstanding SHALL be dropped: no operand capture, no response, and no change to state.
REQ-022 Because tags are unique and the FIFO is 4 deep, the FIFO SHALL never overflow; the overflow path SHALL be unreachable.

Reset
REQ-023 While reset is high, intake SHALL be IDLE, the pipeline and FIFO SHALL be empty, the tag mask SHALL be 0, and all outputs SHALL be 0 in the cycle after reset is sampled.
REQ-024 Reset asserted mid-operation, including in OP2 or with results in flight, SHALL discard all pending work without emitting any response.
REQ-025 A command in the first cycle after reset deasserts SHALL be accepted.

Configuration
REQ-026 With `CALC_SHIFT_EN` defined, cmds 5 and 6 SHALL execute per REQ-014 and REQ-017.
REQ-027 Without `CALC_SHIFT_EN`, cmds 5 and 6 SHALL be treated as invalid (REQ-015, add latency), and the shift pipeline SHALL be omitted.

Verification
REQ-028 add: op1=5, op2=7, tag 1 at N → resp 1, data 12, tag 1 at N+3 only.
REQ-029 add: FFFFFFFF+1, tag 2 → resp 2, data 0 at N+3; sub: 3−4 → resp 2, data 0.
REQ-030 (shift enabled) shl op1=1, op2=0x24 (amount 4), tag 0 at N; add 1+1, tag 3 at N+2 → both complete at N+5; tag 0 (data 16) is driven at N+5 and tag 3 (data 2) at N+6.
REQ-031 cmd 9, tag 1 → resp 2, data 0 at N+3; a repeat with tag 1 at N+2 (tag still outstanding) → dropped, exactly one response.
REQ-032 Add issued, reset pulsed at N+1 → no response at any later cycle; outputs 0; tag 1 is reusable immediately.
REQ-033 (shift disabled) shr 8>>1, tag 2 → resp 2, data 0 at N+3.
